// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 clock, captures 11-bit frames,
// handles F0/E0 prefixes, and tracks the W/A/S/D keys to produce a movement direction.
module ps2_key_ctrl #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       break_flag,
    output logic       ext_flag,
    output logic       frame_err,
    output logic [3:0] key_held,
    output logic [2:0] dir
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    csync_q, csync_d, dsync_q, dsync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          pend_brk_q, pend_brk_d, pend_ext_q, pend_ext_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          code_valid_q, code_valid_d, break_q, break_d, ext_q, ext_d;
    logic          frame_err_q, frame_err_d;
    logic [3:0]    held_q, held_d;
    logic [2:0]    dir_q, dir_d;
    logic          fall, bit_in, good, hit;
    logic [1:0]    idx;
    logic [7:0]    code;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            csync_q      <= 2'b11;
            dsync_q      <= 2'b11;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            tmo_q        <= '0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            pend_brk_q   <= 1'b0;
            pend_ext_q   <= 1'b0;
            scan_code_q  <= '0;
            code_valid_q <= 1'b0;
            break_q      <= 1'b0;
            ext_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            held_q       <= '0;
            dir_q        <= 3'b111;
        end else begin
            state_q      <= state_d;
            csync_q      <= csync_d;
            dsync_q      <= dsync_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            tmo_q        <= tmo_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            pend_brk_q   <= pend_brk_d;
            pend_ext_q   <= pend_ext_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            break_q      <= break_d;
            ext_q        <= ext_d;
            frame_err_q  <= frame_err_d;
            held_q       <= held_d;
            dir_q        <= dir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        csync_d      = {csync_q[0], ps2_clk};
        dsync_d      = {dsync_q[0], ps2_data};
        filt_d       = filt_q;
        fcnt_d       = '0;
        tmo_d        = tmo_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        pend_brk_d   = pend_brk_q;
        pend_ext_d   = pend_ext_q;
        scan_code_d  = scan_code_q;
        code_valid_d = 1'b0;
        break_d      = break_q;
        ext_d        = ext_q;
        frame_err_d  = 1'b0;
        held_d       = held_q;
        dir_d        = dir_q;
        fall         = 1'b0;
        bit_in       = dsync_q[1];
        code         = shreg_q[7:0];
        good         = (^shreg_q[8:0]) && shreg_q[9];
        hit          = 1'b1;
        idx          = 2'd0;

        // The filtered clock only flips once the raw level has disagreed for FILTER_LEN cycles.
        if (csync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = csync_q[1];
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        case (code)
            8'h1D:   idx = 2'd0;
            8'h1B:   idx = 2'd1;
            8'h1C:   idx = 2'd2;
            8'h23:   idx = 2'd3;
            default: hit = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                tmo_d    = '0;
                if (fall) begin
                    if (!bit_in) begin
                        state_d  = RECV;
                        bitcnt_d = 4'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                tmo_d = tmo_q + 1'b1;
                if (fall) begin
                    tmo_d    = '0;
                    shreg_d  = {bit_in, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd10) state_d = CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    pend_brk_d  = 1'b0;
                    pend_ext_d  = 1'b0;
                end
            end
            CHECK: begin
                state_d  = IDLE;
                bitcnt_d = '0;
                if (!good) begin
                    frame_err_d = 1'b1;
                    pend_brk_d  = 1'b0;
                    pend_ext_d  = 1'b0;
                end else if (code == 8'hF0) begin
                    pend_brk_d = 1'b1;
                end else if (code == 8'hE0) begin
                    pend_ext_d = 1'b1;
                end else begin
                    code_valid_d = 1'b1;
                    scan_code_d  = code;
                    break_d      = pend_brk_q;
                    ext_d        = pend_ext_q;
                    pend_brk_d   = 1'b0;
                    pend_ext_d   = 1'b0;
                    if (hit && !pend_ext_q) begin
                        if (!pend_brk_q) begin
                            held_d[idx] = 1'b1;
                            dir_d       = {1'b0, idx};
                        end else begin
                            held_d[idx] = 1'b0;
                            // Releasing the steering key hands control to the best remaining key.
                            if (dir_q == {1'b0, idx}) begin
                                if (held_d[0])      dir_d = 3'b000;
                                else if (held_d[1]) dir_d = 3'b001;
                                else if (held_d[2]) dir_d = 3'b010;
                                else if (held_d[3]) dir_d = 3'b011;
                                else                dir_d = 3'b111;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign break_flag = break_q;
    assign ext_flag   = ext_q;
    assign frame_err  = frame_err_q;
    assign key_held   = held_q;
    assign dir        = dir_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed frames plus random traffic against a key-set model.
module tb_ps2_key_ctrl;
    localparam int H   = 10;
    localparam int TMO = 300;

    logic       Clk = 1'b0, Reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, break_flag, ext_flag, frame_err;
    logic [3:0] key_held;
    logic [2:0] dir;

    ps2_key_ctrl #(.FILTER_LEN(4), .TIMEOUT_CYC(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .code_valid(code_valid), .break_flag(break_flag),
        .ext_flag(ext_flag), .frame_err(frame_err), .key_held(key_held), .dir(dir)
    );

    always #10 Clk = ~Clk;

    int cyc = 0, cv_cnt = 0, err_cnt = 0, cv_cyc = 0, fall_cyc = 0;
    logic [7:0] cv_code;
    logic cv_brk, cv_ext;
    int checks = 0, errors = 0;

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (code_valid === 1'b1) begin
            cv_cnt  <= cv_cnt + 1;
            cv_cyc  <= cyc;
            cv_code <= scan_code;
            cv_brk  <= break_flag;
            cv_ext  <= ext_flag;
        end
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    // Reference model: set of held keys, steering key, pending prefixes.
    logic [7:0] keys [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    bit m_held [4];
    int m_dir;
    bit m_brk, m_ext;

    function automatic int key_idx(input logic [7:0] c);
        for (int i = 0; i < 4; i++) if (keys[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [3:0] held_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_held[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_dir = 7; m_brk = 0; m_ext = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk) ps2_data = b;
        repeat (H) @(negedge Clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (H) @(negedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] code, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        @(negedge Clk) ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] code, input bit bad_par);
        int cv0, e0, k;
        bit exp_cv, exp_err, exp_brk, exp_ext;
        cv0 = cv_cnt; e0 = err_cnt;
        exp_cv = 0; exp_err = 0; exp_brk = m_brk; exp_ext = m_ext;
        send_raw(code, bad_par, 11);
        repeat (3) @(negedge Clk);
        if (bad_par) begin
            exp_err = 1; m_brk = 0; m_ext = 0;
        end else if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) m_ext = 1;
        else begin
            exp_cv = 1;
            k = key_idx(code);
            if (!m_ext && k >= 0) begin
                if (!m_brk) begin
                    m_held[k] = 1; m_dir = k;
                end else begin
                    m_held[k] = 0;
                    if (m_dir == k) begin
                        m_dir = 7;
                        for (int i = 3; i >= 0; i--) if (m_held[i]) m_dir = i;
                    end
                end
            end
            m_brk = 0; m_ext = 0;
        end
        chk("cv_pulses", cv_cnt - cv0, exp_cv);
        chk("err_pulses", err_cnt - e0, exp_err);
        if (exp_cv) begin
            chk("latency", cv_cyc - fall_cyc, 7);
            chk("scan_code", cv_code, code);
            chk("break_flag", cv_brk, exp_brk);
            chk("ext_flag", cv_ext, exp_ext);
        end
        chk("key_held", key_held, held_vec());
        chk("dir", dir, m_dir[2:0]);
    endtask

    initial begin
        int e0, cv0, r;
        logic [7:0] c;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_cv", code_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_held", key_held, 4'b0000);
        chk("rst_dir", dir, 3'b111);
        @(negedge Clk) Reset = 1'b1;
        repeat (5) @(negedge Clk);

        do_frame(8'h1D, 0);
        do_frame(8'h1C, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h1C, 0);
        do_frame(8'h1D, 1);
        do_frame(8'hF0, 0);
        do_frame(8'h1D, 0);

        // Timeout after 5 bits, with a pending F0 that must be discarded.
        do_frame(8'hF0, 0);
        e0 = err_cnt;
        send_raw(8'h55, 0, 5);
        repeat (TMO + 20) @(negedge Clk);
        chk("timeout_err", err_cnt - e0, 1);
        m_brk = 0; m_ext = 0;
        do_frame(8'h1B, 0);

        do_frame(8'hE0, 0);
        do_frame(8'h1D, 0);

        // Short clock glitch in idle must not be seen as a start bit.
        e0 = err_cnt; cv0 = cv_cnt;
        @(negedge Clk) ps2_clk = 1'b0;
        repeat (2) @(negedge Clk);
        ps2_clk = 1'b1;
        repeat (12) @(negedge Clk);
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_cv", cv_cnt - cv0, 0);
        do_frame(8'h1C, 0);

        // Reset mid-frame.
        send_raw(8'h1B, 0, 6);
        Reset = 1'b0;
        #1;
        chk("mid_rst_held", key_held, 4'b0000);
        chk("mid_rst_dir", dir, 3'b111);
        chk("mid_rst_scan", scan_code, 8'h00);
        chk("mid_rst_flags", {code_valid, break_flag, ext_flag, frame_err}, 4'b0000);
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        do_frame(8'h23, 0);

        for (int n = 0; n < 45; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: c = keys[r];
                4, 5:       c = 8'hF0;
                6:          c = 8'hE0;
                default:    c = 8'($urandom_range(0, 255));
            endcase
            do_frame(c, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
